// File: rtl/fb_port_arb_pkg.sv
// Shared types and default geometry for the framebuffer port arbiter.
package fb_port_arb_pkg;

    // Arbiter states; ST_CLEAR is only reachable when FB_PORT_ARB_CLEAR_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CLEAR
    } state_t;

    // Default framebuffer geometry: 160x90 pixels, each line shown on 4 screen lines.
    localparam int unsigned DEF_FB_WIDTH  = 160;
    localparam int unsigned DEF_FB_HEIGHT = 90;
    localparam int unsigned DEF_FB_SCALE  = 4;

endpackage

// File: rtl/fb_port_arb_if.sv
// Draw-pipeline write handshake into the framebuffer port arbiter.
interface fb_port_arb_if #(
    parameter int unsigned ADDRW = 14,
    parameter int unsigned DATAW = 2
);
    logic             draw_valid;
    logic             draw_ready;
    logic [ADDRW-1:0] draw_addr;
    logic [DATAW-1:0] draw_data;

    modport master (output draw_valid, output draw_addr, output draw_data, input draw_ready);
    modport slave  (input draw_valid, input draw_addr, input draw_data, output draw_ready);
endinterface

// File: rtl/fb_fill_seq.sv
// Vertical scale counter: decides on which line pulses a linebuffer fill burst starts.
module fb_fill_seq
    import fb_port_arb_pkg::*;
#(
    parameter int unsigned FB_SCALE = DEF_FB_SCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame,
    input  logic line,
    input  logic line0,
    output logic fill_start
);
    logic [5:0] cnt_line;
    logic [5:0] cnt_line_next;
    logic       lb_line;
    logic       lb_line_next;

    // Apply this cycle's frame/line0/line updates; line0 overrides frame for lb_line.
    always_comb begin
        cnt_line_next = cnt_line;
        lb_line_next  = lb_line;
        if (frame) begin
            lb_line_next = 1'b0;
        end
        if (line0) begin
            cnt_line_next = '0;
            lb_line_next  = 1'b1;
        end else if (line) begin
            cnt_line_next = (cnt_line == 6'(FB_SCALE - 1)) ? '0 : cnt_line + 6'd1;
        end
        fill_start = line && lb_line_next && (cnt_line_next == '0);
    end

    // Scale counter and in-framebuffer-area flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_line <= '0;
            lb_line  <= 1'b0;
        end else begin
            cnt_line <= cnt_line_next;
            lb_line  <= lb_line_next;
        end
    end
endmodule

// File: rtl/fb_port_arb.sv
// Framebuffer BRAM port arbiter: display linebuffer fill bursts have absolute
// priority over draw-pipeline writes. Optional clear engine: FB_PORT_ARB_CLEAR_EN.
module fb_port_arb
    import fb_port_arb_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = DEF_FB_WIDTH,
    parameter int unsigned FB_HEIGHT = DEF_FB_HEIGHT,
    parameter int unsigned FB_SCALE  = DEF_FB_SCALE,
    parameter int unsigned ADDRW     = 14,
    parameter int unsigned DATAW     = 2,
    parameter int unsigned CLEAR_IDX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             line,
    input  logic             line0,
    fb_port_arb_if.slave     draw,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr_write,
    output logic [DATAW-1:0] mem_din,
    output logic [ADDRW-1:0] mem_addr_read,
    output logic             lb_en_in,
    output logic             fill_busy,
    output logic             overrun,
    output logic             clear_busy
);
    localparam int unsigned      XW       = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam logic [XW-1:0]    X_LAST   = XW'(FB_WIDTH - 1);
    localparam logic [ADDRW-1:0] CLR_LAST = ADDRW'(FB_WIDTH * FB_HEIGHT - 1);

    state_t           state;
    state_t           state_next;
    logic [XW-1:0]    cnt_x;
    logic             fill_start;
    logic             clr_arm;
    logic             clr_pending;
    logic             clear_we;
    logic [ADDRW-1:0] clr_addr;

    fb_fill_seq #(.FB_SCALE(FB_SCALE)) u_fill_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame      (frame),
        .line       (line),
        .line0      (line0),
        .fill_start (fill_start)
    );

`ifdef FB_PORT_ARB_CLEAR_EN
    assign clr_arm = frame;
`else
    assign clr_arm = 1'b0;
`endif

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fill preempts everything; clear resumes after a fill.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fill_start) begin
                    state_next = ST_FILL;
                end
`ifdef FB_PORT_ARB_CLEAR_EN
                else if (clr_pending) begin
                    state_next = ST_CLEAR;
                end
`endif
            end
            ST_FILL: begin
                if (cnt_x == X_LAST) begin
`ifdef FB_PORT_ARB_CLEAR_EN
                    state_next = clr_pending ? ST_CLEAR : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_CLEAR: begin
                if (fill_start) begin
                    state_next = ST_FILL;
                end else if (clear_we && (clr_addr == CLR_LAST) && !clr_arm) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Burst counter, read address, BRAM-latency-aligned linebuffer enable, sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x         <= '0;
            mem_addr_read <= '0;
            lb_en_in      <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            lb_en_in <= (state == ST_FILL);
            cnt_x    <= ((state == ST_FILL) && (cnt_x != X_LAST)) ? cnt_x + XW'(1) : '0;
            if (line && (state == ST_FILL)) begin
                overrun <= 1'b1;
            end
            if (frame) begin
                mem_addr_read <= '0;
            end else if (state == ST_FILL) begin
                mem_addr_read <= mem_addr_read + ADDRW'(1);
            end
        end
    end

    // Clear request and progress; the address survives a fill so the clear resumes in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pending <= 1'b0;
            clr_addr    <= '0;
        end else if (clr_arm) begin
            clr_pending <= 1'b1;
            clr_addr    <= '0;
        end else if (clear_we) begin
            if (clr_addr == CLR_LAST) begin
                clr_pending <= 1'b0;
                clr_addr    <= '0;
            end else begin
                clr_addr <= clr_addr + ADDRW'(1);
            end
        end
    end

    // Write-port mux and handshake; draw_ready is held low while in reset.
    always_comb begin
        fill_busy       = (state == ST_FILL);
        clear_busy      = clr_pending;
        clear_we        = (state == ST_CLEAR) && !fill_start;
        draw.draw_ready = rst_n && (state == ST_IDLE) && !fill_start && !clr_pending;
        mem_we          = clear_we || (draw.draw_valid && draw.draw_ready);
        mem_addr_write  = clear_we ? clr_addr : draw.draw_addr;
        mem_din         = clear_we ? DATAW'(CLEAR_IDX) : draw.draw_data;
    end
endmodule

// File: tb/tb_fb_port_arb.sv
// Scoreboard bench for fb_port_arb: stimulus pushes expected reads/writes, a
// negedge monitor pops and compares them. Also covers FB_PORT_ARB_CLEAR_EN builds.
module tb_fb_port_arb;
    import fb_port_arb_pkg::*;

    localparam int unsigned W    = 160;
    localparam int unsigned H    = 90;
    localparam int unsigned S    = 4;
    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 2;
    localparam int unsigned CIDX = 0;
    localparam int unsigned LP   = 164;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame = 1'b0;
    logic          line = 1'b0;
    logic          line0 = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr_write;
    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_addr_read;
    logic          lb_en_in;
    logic          fill_busy;
    logic          overrun;
    logic          clear_busy;

    fb_port_arb_if #(.ADDRW(AW), .DATAW(DW)) dif ();

    fb_port_arb #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .FB_SCALE(S), .ADDRW(AW), .DATAW(DW), .CLEAR_IDX(CIDX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame          (frame),
        .line           (line),
        .line0          (line0),
        .draw           (dif),
        .mem_we         (mem_we),
        .mem_addr_write (mem_addr_write),
        .mem_din        (mem_din),
        .mem_addr_read  (mem_addr_read),
        .lb_en_in       (lb_en_in),
        .fill_busy      (fill_busy),
        .overrun        (overrun),
        .clear_busy     (clear_busy)
    );

    always #5 clk = ~clk;

    int unsigned   nchk = 0;
    int unsigned   nfail = 0;
    logic [AW-1:0] rd_q[$];
    wr_t           wr_q[$];
    int unsigned   rd_base = 0;
    int unsigned   clr_exp = 0;
    int unsigned   clr_cnt = 0;
    logic [AW-1:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every linebuffer enable and every BRAM write is matched against the queues.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        wr_t           ew;
        if (rst_n) begin
            if (lb_en_in) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", {31'd0, lb_en_in}, 32'd0);
                end else begin
                    ea = rd_q.pop_front();
                    check("rd_addr", {18'd0, prev_addr}, {18'd0, ea});
                end
            end
            if (mem_we) begin
                if (clear_busy) begin
                    check("clr_addr", {18'd0, mem_addr_write}, clr_exp);
                    check("clr_data", {30'd0, mem_din}, CIDX);
                    clr_exp++;
                    clr_cnt++;
                end else if (wr_q.size() == 0) begin
                    check("wr_unexpected", {31'd0, mem_we}, 32'd0);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", {18'd0, mem_addr_write}, {18'd0, ew.a});
                    check("wr_data", {30'd0, mem_din}, {30'd0, ew.d});
                end
            end
        end
        prev_addr = mem_addr_read;
    end

    task automatic push_reads(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            rd_q.push_back(AW'(rd_base + i));
        end
    endtask

    // One line pulse followed by a full line period; checks burst shape when a fill is due.
    task automatic run_line(input bit l0, input bit exp_fill);
        int fb_cnt = 0;
        int lb_cnt = 0;
        int first_fb = -1;
        int first_lb = -1;
        @(posedge clk); #1;
        line = 1'b1;
        line0 = l0;
        if (exp_fill) begin
            push_reads(W);
            rd_base += W;
        end
        for (int k = 0; k < int'(LP); k++) begin
            @(negedge clk);
            if (fill_busy) begin fb_cnt++; if (first_fb < 0) first_fb = k; end
            if (lb_en_in)  begin lb_cnt++; if (first_lb < 0) first_lb = k; end
            if (k == 0) begin @(posedge clk); #1; line = 1'b0; line0 = 1'b0; end
        end
        if (exp_fill) begin
            check("burst_fill_cycles", fb_cnt, W);
            check("burst_lb_cycles", lb_cnt, W);
            check("burst_fill_start", first_fb, 1);
            check("burst_lb_start", first_lb, 2);
        end else begin
            check("no_burst", fb_cnt + lb_cnt, 0);
        end
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1;
        frame = 1'b1;
        rd_base = 0;
        clr_exp = 0;
        clr_cnt = 0;
        @(posedge clk); #1;
        frame = 1'b0;
        @(negedge clk);
        check("frame_addr_rst", {18'd0, mem_addr_read}, 32'd0);
    endtask

    // Waits out a clear (bounded); draw_ready must stay low the whole time.
    task automatic wait_clear();
        int unsigned guard = 0;
        int unsigned viol = 0;
        while (clear_busy && guard < 20000) begin
            if (dif.draw_ready) viol++;
            @(negedge clk);
            guard++;
        end
        check("clear_done_in_time", {31'd0, clear_busy}, 32'd0);
        check("ready_during_clear", viol, 0);
        check("clear_write_count", clr_cnt, W * H);
    endtask

    initial begin
        int low;
        int early_we;
        int fb_cnt;

        // Reset state, with a draw request pending to prove writes are gated.
        dif.draw_valid = 1'b1;
        dif.draw_addr  = '1;
        dif.draw_data  = '1;
        repeat (3) @(negedge clk);
        check("rst_addr_read", {18'd0, mem_addr_read}, 32'd0);
        check("rst_lb_en", {31'd0, lb_en_in}, 32'd0);
        check("rst_fill_busy", {31'd0, fill_busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_draw_ready", {31'd0, dif.draw_ready}, 32'd0);
        dif.draw_valid = 1'b0;
        rst_n = 1'b1;

        // Full frame: 360 screen lines from line0 give 90 bursts.
        frame_pulse();
`ifdef FB_PORT_ARB_CLEAR_EN
        wait_clear();
`endif
        run_line(1'b1, 1'b1);
        for (int i = 1; i < int'(H * S); i++) begin
            run_line(1'b0, (i % int'(S)) == 0);
        end
        check("addr_after_frame", {18'd0, mem_addr_read}, W * H);
        frame_pulse();

`ifdef FB_PORT_ARB_CLEAR_EN
        // A fill preempts the running clear; the monitor checks it resumes in sequence.
        repeat (1000) @(negedge clk);
        check("clear_running", {31'd0, clear_busy}, 32'd1);
        @(posedge clk); #1;
        dif.draw_valid = 1'b1;
        dif.draw_addr  = AW'(14'h0055);
        dif.draw_data  = DW'(1);
        wr_q.push_back('{a: AW'(14'h0055), d: DW'(1)});
        run_line(1'b1, 1'b1);
        wait_clear();
        @(posedge clk); #1;
        dif.draw_valid = 1'b0;
`endif

        // Draw request arriving with a fill-starting line waits out the whole burst.
        @(posedge clk); #1;
        line = 1'b1;
        line0 = 1'b1;
        dif.draw_valid = 1'b1;
        dif.draw_addr  = AW'(14'h0123);
        dif.draw_data  = DW'(2);
        push_reads(W);
        rd_base += W;
        wr_q.push_back('{a: AW'(14'h0123), d: DW'(2)});
        low = 0;
        early_we = 0;
        for (int k = 0; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            if (k <= int'(W) && !dif.draw_ready) low++;
            if (k <= int'(W) && mem_we) early_we++;
            if (k == int'(W) + 1) begin
                check("draw_ready_after_burst", {31'd0, dif.draw_ready}, 32'd1);
                check("mem_we_after_burst", {31'd0, mem_we}, 32'd1);
            end
            if (k == 0) begin @(posedge clk); #1; line = 1'b0; line0 = 1'b0; end
        end
        @(posedge clk); #1;
        dif.draw_valid = 1'b0;
        check("draw_ready_low_cycles", low, W + 1);
        check("no_write_during_burst", early_we, 0);

        // Idle draw at the top address is accepted immediately.
        @(posedge clk); #1;
        dif.draw_valid = 1'b1;
        dif.draw_addr  = '1;
        dif.draw_data  = DW'(3);
        wr_q.push_back('{a: '1, d: DW'(3)});
        @(negedge clk);
        check("idle_draw_ready", {31'd0, dif.draw_ready}, 32'd1);
        check("idle_mem_we", {31'd0, mem_we}, 32'd1);
        @(posedge clk); #1;
        dif.draw_valid = 1'b0;

        // Scaled lines without a burst, then a burst with a line injected 50 cycles in.
        for (int i = 1; i < int'(S); i++) run_line(1'b0, 1'b0);
        @(posedge clk); #1;
        line = 1'b1;
        push_reads(W);
        rd_base += W;
        fb_cnt = 0;
        for (int k = 0; k < int'(LP); k++) begin
            @(negedge clk);
            if (fill_busy) fb_cnt++;
            if (k == 50) check("overrun_before", {31'd0, overrun}, 32'd0);
            if (k == 51) check("overrun_set", {31'd0, overrun}, 32'd1);
            if (k == 0 || k == 50) begin @(posedge clk); #1; line = 1'b0; end
            if (k == 49) begin @(posedge clk); #1; line = 1'b1; end
        end
        check("overrun_burst_len", fb_cnt, W);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset 80 cycles into a burst: outputs clear asynchronously, no fill afterwards.
        @(posedge clk); #1;
        line = 1'b1;
        line0 = 1'b1;
        push_reads(79);
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            if (k == 0) begin @(posedge clk); #1; line = 1'b0; line0 = 1'b0; end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr_read", {18'd0, mem_addr_read}, 32'd0);
        check("arst_lb_en", {31'd0, lb_en_in}, 32'd0);
        check("arst_fill_busy", {31'd0, fill_busy}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        check("arst_clear_busy", {31'd0, clear_busy}, 32'd0);
        rd_base = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) run_line(1'b0, 1'b0);

        check("reads_outstanding", rd_q.size(), 0);
        check("writes_outstanding", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
